merge_fill_arb: RTL and testbench
=================================

# merge_fill_arb

Round-robin fill-request arbiter and response router for the array of parallel slow merge blocks. It collects per-block bin-fill requests (`send_fill_req_blk_slow`, `bin_to_fill_addr_blk_slow`) and serialises them onto one shared memory-fetch port. It returns `fill_req_accepted_blk_slow` to the winner and steers the fetched data into that block's input-bin write port (`wr_en_unit_input`, `wr_addr_unit_input`, `data_in_unit`). It sits between the slow merge block array and the input-fetch/DMA engine.

## Interface
- `NUM_SLOW_BLK`, default `` `NUM_SEG_PER_STG ``: number of requesting slow blocks (≥2).
- `ADDR_W`, default `` `BITS_INPUT_ADDR_SLOW_BLK ``: bin address width.
- `DATA_W`, default `` `BLK_SLOW_PARR_WR_NUM*`DATA_WIDTH_INPUT ``: one write beat.
- `BEATS`, default 1: response beats per fill (≥1).
- `TIMEOUT`, default 255: watchdog limit in cycles (used only with the macro).

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst_b` in 1: reset, synchronous, active-low.
- `unit_en` in 1: when low, no new grant is issued.
- `send_fill_req` in `NUM_SLOW_BLK`: level request per block.
- `bin_to_fill_addr` in `NUM_SLOW_BLK`×`ADDR_W`: bin address per block.
- `fill_req_accepted` out `NUM_SLOW_BLK`: one-hot, 1-cycle accept pulse.
- `mem_req_valid` out 1; `mem_req_ready` in 1: fetch request handshake.
- `mem_req_blk` out $clog2(NUM_SLOW_BLK): winner index.
- `mem_req_addr` out `ADDR_W`: winner's bin address.
- `mem_rsp_valid` in 1; `mem_rsp_data` in `DATA_W`: response beats (no backpressure).
- `wr_en_unit_input` out `NUM_SLOW_BLK`: one-hot write strobe.
- `wr_addr_unit_input` out `ADDR_W`: broadcast address.
- `data_in_unit` out `DATA_W`: broadcast data.
- `beat_idx` out $clog2(BEATS)+1: beat index of the current write.
- `busy` out 1: high whenever the state is not IDLE.
- `fill_timeout_err` out 1: sticky error flag (only with the macro).

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if `unit_en` is high and any request is set, pick the first requester at or after `rr_ptr` in cyclic order. Latch its index and address. Go to REQ next cycle.
- REQ: `mem_req_valid`=1 with the latched blk/addr, held stable until `mem_req_ready`.
  - In the handshake cycle, `fill_req_accepted[winner]`=1 (combinational, valid&ready).
  - Next state is RESP. Beat counter is cleared.
- RESP: each `mem_rsp_valid` beat is registered.
  - Next cycle: `wr_en_unit_input[winner]`=1, `wr_addr_unit_input`=latched addr, `data_in_unit`=beat, `beat_idx`=counter.
  - Counter increments per beat.
  - On beat `BEATS`-1: go to IDLE and set `rr_ptr`=(winner+1) mod `NUM_SLOW_BLK`.
- Requests are sampled only in IDLE. A request withdrawn after latching does not cancel the transaction. Requests arriving in REQ/RESP wait.
- `unit_en` low in REQ/RESP: the in-flight fill completes; only new grants are blocked.
- `mem_rsp_valid` in IDLE/REQ is ignored (no write).
- Reset values:
  - State=IDLE, `rr_ptr`=0, counter=0.
  - All outputs 0, including `wr_en_unit_input`, `data_in_unit` and `fill_timeout_err`.
- Reset asserted mid-transaction aborts it with no accept or write after the reset edge.

## Timing
- Request to `mem_req_valid`: 1 cycle (request seen in IDLE at edge N, valid from N+1).
- Accept pulse: same cycle as the handshake. Earliest is 1 cycle after the request.
- Response to write: exactly 1 cycle.
- Back-to-back fills: after the last-beat edge the FSM is in IDLE for one cycle, so the minimum gap between the last write of one fill and the next `mem_req_valid` is 1 cycle.
- At most one `wr_en_unit_input` bit and one `fill_req_accepted` bit are high per cycle.

## Configuration
- `MERGE_FILL_ARB_TIMEOUT_EN` defined: a counter in REQ/RESP resets on every handshake or response beat.
  - When it reaches `TIMEOUT`, set `fill_timeout_err` (sticky until reset) and return to IDLE.
  - `rr_ptr` advances past the winner. No further writes occur for the aborted fill.
- Macro undefined: no watchdog. `fill_timeout_err` is tied to 0. REQ/RESP wait indefinitely.

## Test plan
- Single request: blk 2 requests addr 5, ready=1, BEATS=1, one response 0xA5 → `mem_req_valid` at cycle 1, `accepted`[2] at cycle 1, `wr_en`[2]=1 with addr 5 and data 0xA5 one cycle after the response.
- All requests: all 4 blocks hold requests continuously → grants in order 0,1,2,3,0. Each block gets exactly one accept per round.
- Backpressure: `mem_req_ready` low for 6 cycles → valid/blk/addr stay stable. Exactly one accept pulse occurs, on the ready cycle.
- BEATS=4 with gaps: response beats at cycles t, t+3, t+4, t+9 → four writes with `beat_idx` 0..3, each one cycle after its beat. IDLE is entered after the 4th beat.
- Gating and reset: `unit_en`=0 with a pending request → no grant. `rst_b`=0 mid-RESP → next cycle all outputs 0, state IDLE, `rr_ptr`=0.
- Watchdog (macro defined, TIMEOUT=8): no response after handshake → `fill_timeout_err`=1 after 8 cycles. The next requester is granted.

Source files
------------

// File: rtl/merge_fill_arb_if.sv
// merge_fill_arb_if
//   Bundles the per-block fill request lines, the shared memory-fetch
//   handshake and the broadcast input-bin write port of merge_fill_arb.
//   master : arbiter side (drives accept, fetch request and bin writes)
//   slave  : block array / fetch engine side
//   Signals: send_fill_req, bin_to_fill_addr, fill_req_accepted,
//            mem_req_valid/ready/blk/addr, mem_rsp_valid/data,
//            wr_en_unit_input, wr_addr_unit_input, data_in_unit, beat_idx

`ifndef NUM_SEG_PER_STG
`define NUM_SEG_PER_STG 4
`endif
`ifndef BITS_INPUT_ADDR_SLOW_BLK
`define BITS_INPUT_ADDR_SLOW_BLK 8
`endif
`ifndef BLK_SLOW_PARR_WR_NUM
`define BLK_SLOW_PARR_WR_NUM 1
`endif
`ifndef DATA_WIDTH_INPUT
`define DATA_WIDTH_INPUT 32
`endif

interface merge_fill_arb_if #(
    parameter int unsigned NUM_SLOW_BLK = `NUM_SEG_PER_STG,
    parameter int unsigned ADDR_W       = `BITS_INPUT_ADDR_SLOW_BLK,
    parameter int unsigned DATA_W       = `BLK_SLOW_PARR_WR_NUM*`DATA_WIDTH_INPUT,
    parameter int unsigned BEATS        = 1
);
    localparam int unsigned BLK_W = $clog2(NUM_SLOW_BLK);
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;

    logic [NUM_SLOW_BLK-1:0]             send_fill_req;
    logic [NUM_SLOW_BLK-1:0][ADDR_W-1:0] bin_to_fill_addr;
    logic [NUM_SLOW_BLK-1:0]             fill_req_accepted;
    logic                                mem_req_valid;
    logic                                mem_req_ready;
    logic [BLK_W-1:0]                    mem_req_blk;
    logic [ADDR_W-1:0]                   mem_req_addr;
    logic                                mem_rsp_valid;
    logic [DATA_W-1:0]                   mem_rsp_data;
    logic [NUM_SLOW_BLK-1:0]             wr_en_unit_input;
    logic [ADDR_W-1:0]                   wr_addr_unit_input;
    logic [DATA_W-1:0]                   data_in_unit;
    logic [CNT_W-1:0]                    beat_idx;

    modport master (
        input  send_fill_req, bin_to_fill_addr, mem_req_ready,
               mem_rsp_valid, mem_rsp_data,
        output fill_req_accepted, mem_req_valid, mem_req_blk, mem_req_addr,
               wr_en_unit_input, wr_addr_unit_input, data_in_unit, beat_idx
    );

    modport slave (
        output send_fill_req, bin_to_fill_addr, mem_req_ready,
               mem_rsp_valid, mem_rsp_data,
        input  fill_req_accepted, mem_req_valid, mem_req_blk, mem_req_addr,
               wr_en_unit_input, wr_addr_unit_input, data_in_unit, beat_idx
    );
endinterface

// File: rtl/merge_fill_arb.sv
// merge_fill_arb
//   Round-robin arbiter serialising slow-merge-block bin-fill requests onto
//   one memory-fetch port, then steering the returned beats into the
//   winner's input-bin write port.
//   Ports:
//     clk              rising-edge clock
//     rst_b            synchronous active-low reset
//     unit_en          blocks new grants when low (in-flight fill completes)
//     bus              merge_fill_arb_if.master (requests, fetch, bin writes)
//     busy             high whenever the FSM is not IDLE
//     fill_timeout_err sticky watchdog error
//   Optional feature: define MERGE_FILL_ARB_TIMEOUT_EN to enable the
//   REQ/RESP watchdog; otherwise fill_timeout_err is tied to 0.

`ifndef NUM_SEG_PER_STG
`define NUM_SEG_PER_STG 4
`endif
`ifndef BITS_INPUT_ADDR_SLOW_BLK
`define BITS_INPUT_ADDR_SLOW_BLK 8
`endif
`ifndef BLK_SLOW_PARR_WR_NUM
`define BLK_SLOW_PARR_WR_NUM 1
`endif
`ifndef DATA_WIDTH_INPUT
`define DATA_WIDTH_INPUT 32
`endif

module merge_fill_arb #(
    parameter int unsigned NUM_SLOW_BLK = `NUM_SEG_PER_STG,
    parameter int unsigned ADDR_W       = `BITS_INPUT_ADDR_SLOW_BLK,
    parameter int unsigned DATA_W       = `BLK_SLOW_PARR_WR_NUM*`DATA_WIDTH_INPUT,
    parameter int unsigned BEATS        = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           unit_en,
    merge_fill_arb_if.master bus,
    output logic           busy,
    output logic           fill_timeout_err
);
    localparam int unsigned BLK_W = $clog2(NUM_SLOW_BLK);
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [BLK_W-1:0]    r_rr_ptr, r_blk, w_pick, w_cand, w_blk_inc;
    logic [ADDR_W-1:0]   r_addr, r_wr_addr;
    logic [CNT_W-1:0]    r_cnt, r_beat_idx;
    logic [NUM_SLOW_BLK-1:0] r_wr_en;
    logic [DATA_W-1:0]   r_wr_data;
    logic                w_found, w_grant, w_hs, w_beat, w_last, w_abort;
    int unsigned         w_idx;

    // Scan from the highest cyclic offset down so the requester closest at
    // or after r_rr_ptr is the one left in w_pick.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_cand  = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_SLOW_BLK; k++) begin
            w_idx  = (32'(r_rr_ptr) + NUM_SLOW_BLK - 1 - k) % NUM_SLOW_BLK;
            w_cand = BLK_W'(w_idx);
            if (bus.send_fill_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_grant   = (r_state == S_IDLE) && unit_en && w_found;
    assign w_hs      = (r_state == S_REQ)  && bus.mem_req_ready && !w_abort;
    assign w_beat    = (r_state == S_RESP) && bus.mem_rsp_valid && !w_abort;
    assign w_last    = w_beat && (r_cnt == CNT_W'(BEATS - 1));
    assign w_blk_inc = (r_blk == BLK_W'(NUM_SLOW_BLK - 1)) ? '0 : r_blk + BLK_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        bus.fill_req_accepted = '0;
        case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hs) begin
                    w_state_nxt = S_RESP;
                    bus.fill_req_accepted[r_blk] = 1'b1;
                end
            end
            S_RESP: if (w_abort || w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_blk      <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_beat_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_blk  <= w_pick;
                r_addr <= bus.bin_to_fill_addr[w_pick];
            end
            if (w_hs) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last || w_abort) r_rr_ptr <= w_blk_inc;
            r_wr_en <= '0;
            if (w_beat) begin
                r_wr_en[r_blk] <= 1'b1;
                r_wr_addr      <= r_addr;
                r_wr_data      <= bus.mem_rsp_data;
                r_beat_idx     <= r_cnt;
            end
        end
    end

`ifdef MERGE_FILL_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd;
    logic            r_err;

    assign w_abort = (r_state != S_IDLE) && (r_wd == WD_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE || w_hs || w_beat) begin
            r_wd <= '0;
        end else if (w_abort) begin
            r_wd  <= '0;
            r_err <= 1'b1;
        end else begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    assign fill_timeout_err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_abort          = 1'b0;
    assign fill_timeout_err = 1'b0;
`endif

    assign bus.mem_req_valid      = (r_state == S_REQ);
    assign bus.mem_req_blk        = r_blk;
    assign bus.mem_req_addr       = r_addr;
    assign bus.wr_en_unit_input   = r_wr_en;
    assign bus.wr_addr_unit_input = r_wr_addr;
    assign bus.data_in_unit       = r_wr_data;
    assign bus.beat_idx           = r_beat_idx;
    assign busy                   = (r_state != S_IDLE);
endmodule

// File: tb/tb_merge_fill_arb.sv
// tb_merge_fill_arb
//   Directed bench for merge_fill_arb: one instance with BEATS=1 and one with
//   BEATS=4, both 4 blocks, 8-bit address and data.

module tb_merge_fill_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b, unit_en;
    logic busy1, err1, busy4, err4;
    int   n_chk = 0;
    int   n_err = 0;

    merge_fill_arb_if #(.NUM_SLOW_BLK(4), .ADDR_W(8), .DATA_W(8), .BEATS(1)) if1 ();
    merge_fill_arb_if #(.NUM_SLOW_BLK(4), .ADDR_W(8), .DATA_W(8), .BEATS(4)) if4 ();

    merge_fill_arb #(.NUM_SLOW_BLK(4), .ADDR_W(8), .DATA_W(8), .BEATS(1), .TIMEOUT(8)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .unit_en(unit_en), .bus(if1),
        .busy(busy1), .fill_timeout_err(err1)
    );
    merge_fill_arb #(.NUM_SLOW_BLK(4), .ADDR_W(8), .DATA_W(8), .BEATS(4), .TIMEOUT(8)) u_dut4 (
        .clk(clk), .rst_b(rst_b), .unit_en(unit_en), .bus(if4),
        .busy(busy4), .fill_timeout_err(err4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        if1.send_fill_req = '0; if1.bin_to_fill_addr = '0; if1.mem_req_ready = 1'b0;
        if1.mem_rsp_valid = 1'b0; if1.mem_rsp_data = '0;
        if4.send_fill_req = '0; if4.bin_to_fill_addr = '0; if4.mem_req_ready = 1'b0;
        if4.mem_rsp_valid = 1'b0; if4.mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        rst_b   = 1'b0;
        unit_en = 1'b1;
        clr_inputs();
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    int   acc_cnt [4];
    int   pulses, bi;
    logic found, is_beat;
    logic [3:0] acc;

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        rst_b = 1'b0;
        tick();
        chk("rst_valid1", if1.mem_req_valid, 0);
        chk("rst_acc1",   if1.fill_req_accepted, 0);
        chk("rst_wren1",  if1.wr_en_unit_input, 0);
        chk("rst_data1",  if1.data_in_unit, 0);
        chk("rst_bidx1",  if1.beat_idx, 0);
        chk("rst_busy1",  busy1, 0);
        chk("rst_err1",   err1, 0);
        chk("rst_valid4", if4.mem_req_valid, 0);
        chk("rst_wren4",  if4.wr_en_unit_input, 0);
        chk("rst_busy4",  busy4, 0);
        rst_b = 1'b1;

        // ---------------- single request, blk 2 addr 5 ----------------
        if1.send_fill_req = 4'b0100;
        if1.bin_to_fill_addr[2] = 8'h05;
        if1.mem_req_ready = 1'b1;
        tick();
        chk("sr_valid", if1.mem_req_valid, 1);
        chk("sr_blk",   if1.mem_req_blk, 2);
        chk("sr_addr",  if1.mem_req_addr, 8'h05);
        chk("sr_busy",  busy1, 1);
        #1;
        chk("sr_acc",   if1.fill_req_accepted, 4'b0100);
        if1.send_fill_req = '0;
        tick();
        chk("sr_valid_off", if1.mem_req_valid, 0);
        chk("sr_acc_off",   if1.fill_req_accepted, 0);
        chk("sr_wren_pre",  if1.wr_en_unit_input, 0);
        if1.mem_rsp_valid = 1'b1;
        if1.mem_rsp_data  = 8'hA5;
        tick();
        chk("sr_wren",  if1.wr_en_unit_input, 4'b0100);
        chk("sr_waddr", if1.wr_addr_unit_input, 8'h05);
        chk("sr_data",  if1.data_in_unit, 8'hA5);
        chk("sr_bidx",  if1.beat_idx, 0);
        chk("sr_idle",  busy1, 0);
        // response while IDLE must not write
        if1.mem_rsp_data = 8'h77;
        tick();
        chk("idle_rsp_wren", if1.wr_en_unit_input, 0);
        chk("idle_rsp_busy", busy1, 0);
        if1.mem_rsp_valid = 1'b0;

        // ---------------- all four blocks requesting ----------------
        do_reset();
        for (int b = 0; b < 4; b++) begin
            acc_cnt[b] = 0;
            if1.bin_to_fill_addr[b] = 8'(8'h10 + b);
        end
        if1.send_fill_req = 4'b1111;
        if1.mem_req_ready = 1'b1;
        if1.mem_rsp_valid = 1'b1;
        if1.mem_rsp_data  = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 8; w++) begin
                if (!found) begin
                    tick();
                    #1;
                    if (if1.fill_req_accepted != 0) found = 1'b1;
                end
            end
            chk("rr_found", found, 1);
            acc = 4'b0001 << (k % 4);
            chk("rr_acc",  if1.fill_req_accepted, acc);
            chk("rr_blk",  if1.mem_req_blk, k % 4);
            chk("rr_addr", if1.mem_req_addr, 8'h10 + (k % 4));
            for (int b = 0; b < 4; b++) if (if1.fill_req_accepted[b]) acc_cnt[b]++;
        end
        for (int b = 0; b < 4; b++) chk("rr_count", acc_cnt[b], (b == 0) ? 2 : 1);

        // ---------------- backpressure ----------------
        do_reset();
        if1.send_fill_req = 4'b0010;
        if1.bin_to_fill_addr[1] = 8'h3C;
        tick();
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            chk("bp_valid", if1.mem_req_valid, 1);
            chk("bp_blk",   if1.mem_req_blk, 1);
            chk("bp_addr",  if1.mem_req_addr, 8'h3C);
            chk("bp_acc",   if1.fill_req_accepted, 0);
            if (if1.fill_req_accepted != 0) pulses++;
            if (c == 2) begin
                if1.bin_to_fill_addr[1] = 8'hFF;
                if1.send_fill_req = '0;
            end
            tick();
        end
        if1.mem_req_ready = 1'b1;
        #1;
        chk("bp_acc_rdy", if1.fill_req_accepted, 4'b0010);
        if (if1.fill_req_accepted != 0) pulses++;
        tick();
        chk("bp_acc_after", if1.fill_req_accepted, 0);
        if (if1.fill_req_accepted != 0) pulses++;
        chk("bp_valid_after", if1.mem_req_valid, 0);
        chk("bp_pulses", pulses, 1);
        if1.mem_req_ready = 1'b0;

        // ---------------- BEATS=4 with gaps ----------------
        do_reset();
        if4.send_fill_req = 4'b1000;
        if4.bin_to_fill_addr[3] = 8'h21;
        if4.mem_req_ready = 1'b1;
        tick();
        chk("b4_valid", if4.mem_req_valid, 1);
        chk("b4_blk",   if4.mem_req_blk, 3);
        #1;
        chk("b4_acc",   if4.fill_req_accepted, 4'b1000);
        if4.send_fill_req = '0;
        tick();
        bi = 0;
        for (int c = 0; c < 11; c++) begin
            is_beat = (c == 0) || (c == 3) || (c == 4) || (c == 9);
            if4.mem_rsp_valid = is_beat;
            if4.mem_rsp_data  = 8'(8'h10 + bi);
            tick();
            chk("b4_wren", if4.wr_en_unit_input, is_beat ? 4'b1000 : 4'b0000);
            if (is_beat) begin
                chk("b4_bidx",  if4.beat_idx, bi);
                chk("b4_data",  if4.data_in_unit, 8'h10 + bi);
                chk("b4_waddr", if4.wr_addr_unit_input, 8'h21);
                bi++;
            end
            chk("b4_busy", busy4, (bi < 4) ? 1 : 0);
        end
        if4.mem_rsp_valid = 1'b0;

        // ---------------- unit_en gating ----------------
        do_reset();
        unit_en = 1'b0;
        if1.send_fill_req = 4'b0001;
        if1.bin_to_fill_addr[0] = 8'h44;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("gate_valid", if1.mem_req_valid, 0);
            chk("gate_busy",  busy1, 0);
        end
        unit_en = 1'b1;
        tick();
        chk("gate_valid_en", if1.mem_req_valid, 1);
        chk("gate_addr_en",  if1.mem_req_addr, 8'h44);
        unit_en = 1'b0;
        if1.mem_req_ready = 1'b1;
        #1;
        chk("gate_acc_inflight", if1.fill_req_accepted, 4'b0001);
        tick();
        chk("gate_busy_resp", busy1, 1);
        if1.mem_rsp_valid = 1'b1;
        if1.mem_rsp_data  = 8'hEE;
        tick();
        chk("gate_wren", if1.wr_en_unit_input, 4'b0001);
        chk("gate_data", if1.data_in_unit, 8'hEE);
        unit_en = 1'b1;
        if1.mem_rsp_valid = 1'b0;
        if1.send_fill_req = '0;

        // ---------------- reset mid-RESP ----------------
        do_reset();
        if1.send_fill_req = 4'b0010;
        if1.bin_to_fill_addr[1] = 8'h31;
        if1.mem_req_ready = 1'b1;
        tick();
        tick();
        if1.send_fill_req = '0;
        if1.mem_rsp_valid = 1'b1;
        if1.mem_rsp_data  = 8'h99;
        tick();
        chk("mr_first_wren", if1.wr_en_unit_input, 4'b0010);
        if1.mem_rsp_valid = 1'b0;
        if1.send_fill_req = 4'b0100;
        if1.bin_to_fill_addr[2] = 8'h5A;
        tick();
        tick();
        if1.send_fill_req = '0;
        chk("mr_in_resp", busy1, 1);
        rst_b = 1'b0;
        if1.mem_rsp_valid = 1'b1;
        if1.mem_rsp_data  = 8'h66;
        if1.send_fill_req = 4'b1111;
        tick();
        chk("mr_valid", if1.mem_req_valid, 0);
        chk("mr_blk",   if1.mem_req_blk, 0);
        chk("mr_addr",  if1.mem_req_addr, 0);
        chk("mr_wren",  if1.wr_en_unit_input, 0);
        chk("mr_waddr", if1.wr_addr_unit_input, 0);
        chk("mr_data",  if1.data_in_unit, 0);
        chk("mr_bidx",  if1.beat_idx, 0);
        chk("mr_busy",  busy1, 0);
        #1;
        chk("mr_acc",   if1.fill_req_accepted, 0);
        rst_b = 1'b1;
        if1.mem_rsp_valid = 1'b0;
        tick();
        chk("mr_rrptr_blk", if1.mem_req_blk, 0);
        chk("mr_rrptr_vld", if1.mem_req_valid, 1);

`ifdef MERGE_FILL_ARB_TIMEOUT_EN
        // ---------------- watchdog ----------------
        do_reset();
        if1.send_fill_req = 4'b0011;
        if1.mem_req_ready = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 30; w++) begin
            if (!found) begin
                tick();
                if (err1) found = 1'b1;
            end
        end
        chk("wd_err", found, 1);
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (!found) begin
                tick();
                if (if1.mem_req_valid) found = 1'b1;
            end
        end
        chk("wd_regrant", found, 1);
        chk("wd_next_blk", if1.mem_req_blk, 1);
        chk("wd_sticky", err1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
